// File: rtl/frame_flip_scheduler.sv
// frame_flip_scheduler
//
// Purpose:
//   Sequences the double-buffered display memory between the SPI frame loader
//   and the scan driver. A "loaded" event from the loader arms a buffer flip.
//   The flip is taken either on a qualifying frame boundary (tear-free mode)
//   or at once (tearing allowed). A buffer must be shown for a minimum number
//   of frames before the next flip. A stale-frame watchdog can blank the
//   panel when no flip has happened for too long.
//
// Optional feature:
//   FRAME_FLIP_SCHED_STATS_EN - when defined, flip_count and drop_count are
//   live saturating counters. When undefined, both are tied to zero and no
//   counter registers exist.
//
// Ports:
//   clk             system clock (PLL output domain)
//   rst             asynchronous, active-high reset
//   frame_complete  1-cycle pulse from the scan driver at end of frame
//   loaded          1-cycle pulse from the loader: back buffer fully written
//   sync_enable     1 = flip only on frame_complete, 0 = flip on load
//   blank_on_stale  1 = force the panel dark while stale
//   ready           back buffer free, loader may write
//   mem_flip        buffer select to display memory, toggles per flip
//   flip_pulse      1-cycle strobe in the cycle mem_flip toggles
//   stale           watchdog expired
//   blank           output-enable gate (1 = panel dark)
//   flip_count      flips performed (stats)
//   drop_count      loaded pulses ignored while not ready (stats)

module frame_flip_scheduler #(
  parameter int MIN_HOLD_FRAMES = 1,
  parameter int TIMEOUT_FRAMES  = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_complete,
  input  logic                 loaded,
  input  logic                 sync_enable,
  input  logic                 blank_on_stale,
  output logic                 ready,
  output logic                 mem_flip,
  output logic                 flip_pulse,
  output logic                 stale,
  output logic                 blank,
  output logic [CNT_WIDTH-1:0] flip_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  // Limits are clipped to what the counters can hold so they never wrap.
  localparam longint CNT_ALL_ONES = (longint'(1) << CNT_WIDTH) - 1;
  localparam longint HOLD_LIM_L   = (longint'(MIN_HOLD_FRAMES) > CNT_ALL_ONES) ?
                                    CNT_ALL_ONES : longint'(MIN_HOLD_FRAMES);
  localparam longint STALE_LIM_L  = (longint'(TIMEOUT_FRAMES) > CNT_ALL_ONES) ?
                                    CNT_ALL_ONES : longint'(TIMEOUT_FRAMES);

  localparam logic [CNT_WIDTH-1:0] HOLD_LIMIT  = CNT_WIDTH'(HOLD_LIM_L);
  localparam logic [CNT_WIDTH-1:0] STALE_LIMIT = CNT_WIDTH'(STALE_LIM_L);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   ONE_EXT     = (CNT_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_READY   = 2'd0,
    S_PENDING = 2'd1,
    S_FLIP    = 2'd2
  } state_t;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] hold_cnt_reg;
  logic [CNT_WIDTH-1:0] hold_cnt_next;
  logic                 ready_reg;
  logic                 mem_flip_reg;
  logic                 flip_pulse_reg;

  logic hold_ok;
  logic flip_go;

  // Compare one bit wider so hold_cnt+1 cannot overflow at all-ones.
  assign hold_ok = (({1'b0, hold_cnt_reg} + ONE_EXT) >= {1'b0, HOLD_LIMIT});

  // sync_enable is looked at combinationally while pending, so a change
  // takes effect in the same cycle.
  assign flip_go = (state_reg == S_PENDING) &&
                   (!sync_enable || (frame_complete && hold_ok));

  // A frame_complete that triggers the flip is consumed by it; the flip
  // restarts the hold interval from zero.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (flip_go) begin
      hold_cnt_next = '0;
    end else if (frame_complete && (hold_cnt_reg < HOLD_LIMIT)) begin
      hold_cnt_next = hold_cnt_reg + CNT_ONE;
    end
  end

  // Main sequencer; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_READY;
      ready_reg      <= 1'b1;
      mem_flip_reg   <= 1'b0;
      flip_pulse_reg <= 1'b0;
      // Preset so the very first frame after reset is not held back.
      hold_cnt_reg   <= HOLD_LIMIT;
    end else begin
      flip_pulse_reg <= 1'b0;
      hold_cnt_reg   <= hold_cnt_next;
      unique case (state_reg)
        S_READY: begin
          // A frame_complete arriving with the load only advances hold_cnt;
          // the flip test is made from S_PENDING onwards.
          if (loaded) begin
            state_reg <= S_PENDING;
            ready_reg <= 1'b0;
          end
        end
        S_PENDING: begin
          if (flip_go) begin
            state_reg      <= S_FLIP;
            mem_flip_reg   <= ~mem_flip_reg;
            flip_pulse_reg <= 1'b1;
          end
        end
        S_FLIP: begin
          state_reg <= S_READY;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= S_READY;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = ready_reg;
  assign mem_flip   = mem_flip_reg;
  assign flip_pulse = flip_pulse_reg;

  // Stale-frame watchdog.
  generate
    if (TIMEOUT_FRAMES > 0) begin : g_wdog
      logic [CNT_WIDTH-1:0] stale_cnt_reg;
      logic [CNT_WIDTH-1:0] stale_cnt_next;
      logic                 stale_reg;
      logic                 blank_reg;
      logic                 stale_hit;

      assign stale_hit = (stale_cnt_reg == STALE_LIMIT);

      always_comb begin
        stale_cnt_next = stale_cnt_reg;
        if (flip_go) begin
          stale_cnt_next = '0;
        end else if (frame_complete && !stale_hit) begin
          stale_cnt_next = stale_cnt_reg + CNT_ONE;
        end
      end

      // stale follows the counter by one cycle; blank is aligned with it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stale_cnt_reg <= '0;
          stale_reg     <= 1'b0;
          blank_reg     <= 1'b0;
        end else begin
          stale_cnt_reg <= stale_cnt_next;
          if (flip_go) begin
            stale_reg <= 1'b0;
            blank_reg <= 1'b0;
          end else begin
            stale_reg <= stale_hit;
            blank_reg <= stale_hit && blank_on_stale;
          end
        end
      end

      assign stale = stale_reg;
      assign blank = blank_reg;
    end else begin : g_no_wdog
      // Watchdog disabled: blank_on_stale has no effect.
      logic unused_blank_on_stale;
      assign unused_blank_on_stale = blank_on_stale;
      assign stale = 1'b0;
      assign blank = 1'b0;
    end
  endgenerate

  // Statistics counters.
`ifdef FRAME_FLIP_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] flip_count_reg;
  logic [CNT_WIDTH-1:0] drop_count_reg;
  logic                 load_drop;

  // Loads are only accepted in S_READY; anything else is a drop.
  assign load_drop = loaded && (state_reg != S_READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_count_reg <= '0;
      drop_count_reg <= '0;
    end else begin
      if (flip_go && (flip_count_reg != '1)) begin
        flip_count_reg <= flip_count_reg + CNT_ONE;
      end
      if (load_drop && (drop_count_reg != '1)) begin
        drop_count_reg <= drop_count_reg + CNT_ONE;
      end
    end
  end

  assign flip_count = flip_count_reg;
  assign drop_count = drop_count_reg;
`else
  assign flip_count = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_frame_flip_scheduler.sv
// Directed testbench for frame_flip_scheduler.
// Two instances share one stimulus stream:
//   u_a : MIN_HOLD_FRAMES=1, TIMEOUT_FRAMES=4
//   u_b : MIN_HOLD_FRAMES=3, TIMEOUT_FRAMES=0

module tb_frame_flip_scheduler;

  localparam int CW = 16;
`ifdef FRAME_FLIP_SCHED_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic frame_complete;
  logic loaded;
  logic sync_enable;
  logic blank_on_stale;

  logic          a_ready, a_mem_flip, a_flip_pulse, a_stale, a_blank;
  logic [CW-1:0] a_flip_count, a_drop_count;
  logic          b_ready, b_mem_flip, b_flip_pulse, b_stale, b_blank;
  logic [CW-1:0] b_flip_count, b_drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_flip_scheduler #(
    .MIN_HOLD_FRAMES(1),
    .TIMEOUT_FRAMES (4),
    .CNT_WIDTH      (CW)
  ) u_a (
    .clk           (clk),
    .rst           (rst),
    .frame_complete(frame_complete),
    .loaded        (loaded),
    .sync_enable   (sync_enable),
    .blank_on_stale(blank_on_stale),
    .ready         (a_ready),
    .mem_flip      (a_mem_flip),
    .flip_pulse    (a_flip_pulse),
    .stale         (a_stale),
    .blank         (a_blank),
    .flip_count    (a_flip_count),
    .drop_count    (a_drop_count)
  );

  frame_flip_scheduler #(
    .MIN_HOLD_FRAMES(3),
    .TIMEOUT_FRAMES (0),
    .CNT_WIDTH      (CW)
  ) u_b (
    .clk           (clk),
    .rst           (rst),
    .frame_complete(frame_complete),
    .loaded        (loaded),
    .sync_enable   (sync_enable),
    .blank_on_stale(blank_on_stale),
    .ready         (b_ready),
    .mem_flip      (b_mem_flip),
    .flip_pulse    (b_flip_pulse),
    .stale         (b_stale),
    .blank         (b_blank),
    .flip_count    (b_flip_count),
    .drop_count    (b_drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_load();
    loaded = 1'b1;
    tick();
    loaded = 1'b0;
  endtask

  task automatic pulse_fc();
    frame_complete = 1'b1;
    tick();
    frame_complete = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    frame_complete = 1'b0;
    loaded         = 1'b0;
    sync_enable    = 1'b1;
    blank_on_stale = 1'b0;
    idle(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_a_ready", a_ready, 1);
    check("rst_a_mem_flip", a_mem_flip, 0);
    check("rst_a_flip_pulse", a_flip_pulse, 0);
    check("rst_a_stale", a_stale, 0);
    check("rst_a_blank", a_blank, 0);
    check("rst_a_flip_count", a_flip_count, 0);
    check("rst_a_drop_count", a_drop_count, 0);
    check("rst_b_ready", b_ready, 1);

    // Tear-free flip with MIN_HOLD=1: load, wait, flip on frame_complete
    pulse_load();
    check("t1_a_ready_drop", a_ready, 0);
    idle(5);
    check("t1_a_still_pending", a_ready, 0);
    check("t1_a_no_flip_yet", a_mem_flip, 0);
    pulse_fc();
    check("t1_a_flip_pulse", a_flip_pulse, 1);
    check("t1_a_mem_flip", a_mem_flip, 1);
    check("t1_a_ready_in_flip", a_ready, 0);
    check("t1_b_first_flip_unheld", b_mem_flip, 1);
    tick();
    check("t1_a_pulse_end", a_flip_pulse, 0);
    check("t1_a_ready_back", a_ready, 1);
    check("t1_a_flip_count", a_flip_count, 32'(STATS_ON));

    // MIN_HOLD=3: second flip on the 3rd frame_complete after the first
    idle(2);
    pulse_load();
    pulse_fc();
    check("t2_a_second_flip", a_mem_flip, 0);
    check("t2_b_fc1_held", b_mem_flip, 1);
    check("t2_b_fc1_no_pulse", b_flip_pulse, 0);
    idle(3);
    pulse_fc();
    check("t2_b_fc2_held", b_mem_flip, 1);
    idle(3);
    pulse_fc();
    check("t2_b_fc3_pulse", b_flip_pulse, 1);
    check("t2_b_fc3_flip", b_mem_flip, 0);
    tick();
    check("t2_b_ready_back", b_ready, 1);
    check("t2_b_flip_count", b_flip_count, 32'(2 * STATS_ON));

    // sync_enable=0: immediate flip, loaded-to-ready 3 clocks
    do_reset();
    sync_enable = 1'b0;
    pulse_load();
    check("t3_a_ready_drop", a_ready, 0);
    check("t3_a_not_yet", a_mem_flip, 0);
    tick();
    check("t3_a_mem_flip", a_mem_flip, 1);
    check("t3_a_flip_pulse", a_flip_pulse, 1);
    check("t3_b_mem_flip", b_mem_flip, 1);
    tick();
    check("t3_a_ready_back", a_ready, 1);
    check("t3_a_pulse_end", a_flip_pulse, 0);
    sync_enable = 1'b1;

    // Simultaneous loaded + frame_complete in S_READY, then extra load
    do_reset();
    loaded         = 1'b1;
    frame_complete = 1'b1;
    tick();
    loaded         = 1'b0;
    frame_complete = 1'b0;
    check("t4_a_accepted", a_ready, 0);
    check("t4_a_no_pulse", a_flip_pulse, 0);
    check("t4_a_no_flip", a_mem_flip, 0);
    pulse_load();
    check("t4_a_drop_count", a_drop_count, 32'(STATS_ON));
    check("t4_a_still_pending", a_ready, 0);
    idle(3);
    check("t4_a_no_flip_later", a_mem_flip, 0);
    pulse_fc();
    check("t4_a_flip_pulse", a_flip_pulse, 1);
    check("t4_a_mem_flip", a_mem_flip, 1);
    tick();
    check("t4_a_ready_back", a_ready, 1);

    // Watchdog: TIMEOUT=4 with blanking, cleared by a flip
    do_reset();
    blank_on_stale = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_fc();
      idle(2);
    end
    check("t5_a_not_stale_3", a_stale, 0);
    check("t5_a_not_blank_3", a_blank, 0);
    pulse_fc();
    idle(2);
    check("t5_a_stale", a_stale, 1);
    check("t5_a_blank", a_blank, 1);
    check("t5_b_stale_off", b_stale, 0);
    check("t5_b_blank_off", b_blank, 0);
    pulse_load();
    idle(2);
    check("t5_a_stale_held", a_stale, 1);
    pulse_fc();
    tick();
    check("t5_a_stale_clr", a_stale, 0);
    check("t5_a_blank_clr", a_blank, 0);
    check("t5_a_flipped", a_mem_flip, 1);

    // Asynchronous reset while pending
    do_reset();
    blank_on_stale = 1'b1;
    pulse_load();
    pulse_fc();
    idle(2);
    for (int i = 0; i < 4; i++) begin
      pulse_fc();
      idle(2);
    end
    check("t6_a_pre_stale", a_stale, 1);
    check("t6_a_pre_flip", a_mem_flip, 1);
    pulse_load();
    check("t6_a_pending", a_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_a_async_ready", a_ready, 1);
    check("t6_a_async_mem_flip", a_mem_flip, 0);
    check("t6_a_async_stale", a_stale, 0);
    check("t6_a_async_blank", a_blank, 0);
    check("t6_b_async_mem_flip", b_mem_flip, 0);
    #3;
    rst = 1'b0;
    tick();
    pulse_fc();
    check("t6_a_no_flip", a_mem_flip, 0);
    check("t6_a_no_pulse", a_flip_pulse, 0);
    check("t6_b_no_pulse", b_flip_pulse, 0);
    tick();
    check("t6_a_ready", a_ready, 1);
    check("t6_a_still_no_flip", a_mem_flip, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_flip_scheduler.md
Name: frame_flip_scheduler

Overview:
Sequences the double-buffered display memory between the SPI frame loader and the scan driver. It accepts "frame loaded" events from the loader and schedules the buffer flip on a display frame boundary, subject to a minimum hold time per frame. It also enforces a stale-frame watchdog that can blank the panel. It replaces the inline ready/flip logic in the display top level and drives the memory flip select, loader ready and output-enable gating.

Parameters:
MIN_HOLD_FRAMES, 1, minimum number of frame_complete pulses a buffer is displayed before the next flip is allowed (1..255).
TIMEOUT_FRAMES, 0, frame_complete pulses without a flip before stale asserts; 0 disables the watchdog (0..65535).
CNT_WIDTH, 16, width of the hold/stale counters and statistics outputs.

Ports:
clk  input  1  system clock (PLL output domain)
rst  input  1  asynchronous, active-high reset
frame_complete  input  1  single-cycle pulse from the scan driver at the end of a full frame
loaded  input  1  single-cycle pulse from the loader when a complete frame is written to the back buffer
sync_enable  input  1  1 = flip only on frame_complete (tear-free); 0 = flip immediately on load (tearing allowed)
blank_on_stale  input  1  1 = assert blank while stale
ready  output  1  back buffer free; the loader may write
mem_flip  output  1  buffer select to the display memory; toggles on each flip
flip_pulse  output  1  single-cycle strobe in the cycle mem_flip toggles
stale  output  1  watchdog expired
blank  output  1  gate for the driver output enable (1 = force panel dark)
flip_count  output  CNT_WIDTH  flips performed (stats feature)
drop_count  output  CNT_WIDTH  loaded pulses ignored while not ready (stats feature)

Behaviour:
- Reset (async, any time):
  - ready=1, mem_flip=0, flip_pulse=0, stale=0, blank=0, counters=0.
  - hold_cnt is preset to MIN_HOLD_FRAMES, so the first flip is not held.
  - FSM goes to S_READY. Reset mid-load discards the pending frame.
- All outputs are registered.
- FSM:
  - S_READY (ready=1): a loaded pulse moves to S_PENDING; ready drops on the next clock edge (1-cycle latency).
  - S_PENDING (ready=0):
    - Flip condition: (sync_enable=0) OR (frame_complete=1 AND hold_cnt+1 >= MIN_HOLD_FRAMES).
    - When the condition holds, move to S_FLIP.
  - S_FLIP: lasts one cycle. mem_flip toggles, flip_pulse=1, hold_cnt and stale_cnt clear to 0, stale clears. Returns to S_READY; ready=1 on the following edge.
  - Flip latency from the qualifying cycle is 1 clock. loaded to ready is 3 clocks minimum when sync_enable=0.
- hold_cnt: increments on each frame_complete not consumed by a flip; saturates at MIN_HOLD_FRAMES.
- Simultaneous loaded and frame_complete in S_READY:
  - The load is accepted.
  - That frame_complete increments hold_cnt but never flips the new frame; the next qualifying frame_complete is required.
- loaded while in S_PENDING or S_FLIP: ignored; drop_count +1 (saturating). The FSM state is unchanged.
- sync_enable sampled in S_PENDING each cycle. Changing it mid-pending takes effect on the same cycle.
- Watchdog (TIMEOUT_FRAMES>0):
  - stale_cnt increments on each frame_complete, saturating at TIMEOUT_FRAMES.
  - stale=1 registered in the cycle after stale_cnt reaches TIMEOUT_FRAMES.
  - blank = stale AND blank_on_stale (registered).
  - A flip clears stale and blank.
- TIMEOUT_FRAMES=0: stale and blank are held at 0.
- Width rule: all counters are unsigned CNT_WIDTH and saturate at all-ones (or at the stated limit); they never wrap.

Optional Feature:
Macro FRAME_FLIP_SCHED_STATS_EN.
- Defined: flip_count increments on every S_FLIP; drop_count increments as above; both saturating.
- Undefined: flip_count and drop_count are tied to 0 and no counter registers are synthesised. All other behaviour is identical.

Test Plan:
- Reset, then loaded at cycle 10 with sync_enable=1 and MIN_HOLD_FRAMES=1 -> ready=0 at cycle 11; on frame_complete at cycle 50, flip_pulse=1 and mem_flip=1 at cycle 51; ready=1 at cycle 52.
- MIN_HOLD_FRAMES=3, two back-to-back loads -> the second flip occurs on the 3rd frame_complete after the first flip, not earlier.
- sync_enable=0, loaded at cycle 5 -> mem_flip toggles at cycle 7 with no frame_complete; ready=1 at cycle 8.
- loaded and frame_complete in the same cycle in S_READY -> no flip on that frame; flip on the next frame_complete. Extra loaded pulse while pending -> drop_count=1 with FRAME_FLIP_SCHED_STATS_EN defined, 0 without.
- TIMEOUT_FRAMES=4, blank_on_stale=1, no loads -> stale=1 and blank=1 after the 4th frame_complete; a subsequent load and flip clears both.
- Assert rst while in S_PENDING -> ready=1, mem_flip=0, stale=0 immediately (asynchronous); the next frame_complete causes no flip.
